frame_scheduler: RTL and testbench
==================================

# frame_scheduler

Per-frame update sequencer for the stickman runner. It detects the start of each vertical sync on `frame_clk` (VGA_VS) inside the `Clk` domain. It then runs the game's per-frame update engines (physics, scroll/coin, collision/score) strictly one after another, using a start/done handshake per stage. It also maintains the shared `frame_counter`, and flags frames that overrun or stages that hang, so that no engine updates against half-updated state.

## Interface
- `N_STAGES`, default 3: number of sequenced update engines; stage 0 runs first.
- `TIMEOUT`, default 4096: maximum number of `Clk` cycles to wait for `done` in any one stage.
- `CNT_W`, default 12: width of `frame_counter`.

Ports:
- `Clk` in 1: system clock, 50 MHz.
- `Reset` in 1: asynchronous, active-high reset.
- `frame_clk` in 1: VGA_VS. Active-low sync pulse; asynchronous to `Clk`.
- `playing` in 1: game running. When low, no sequences start and the counter holds.
- `done` in N_STAGES: per-stage completion. Only sampled in WAIT for the current stage.
- `clear_err` in 1: one-cycle clear of the sticky error flags.
- `start` out N_STAGES: one-cycle start pulse; one-hot by stage.
- `busy` out 1: high whenever the FSM is not in IDLE.
- `frame_done` out 1: one-cycle pulse when the last stage completes.
- `frame_counter` out CNT_W: count of frames played.
- `overrun` out 1: sticky. A tick arrived while a sequence was busy.
- `timeout_err` out 1: sticky. A stage exceeded `TIMEOUT`.

## Operation
- Synchronizer: three flops `s1 <= frame_clk`, `s2 <= s1`, `s3 <= s2`. All reset to 1.
- `tick = s3 & ~s2`, a falling edge of VS. It is internal and combinational.
- FSM states are IDLE, START, WAIT and FINISH. A stage index register `stg` has ceil(log2 N_STAGES) bits, minimum 1.
- IDLE:
  - `tick` with `playing` = 1: `stg` <= 0, go to START, and `frame_counter` <= `frame_counter` + 1 (mod 2^CNT_W, so 4095 wraps to 0).
  - `tick` with `playing` = 0: ignored. No state change, no count.
- START: `start[stg]` = 1 for exactly this cycle. Load `wait_cnt` <= 0 and go to WAIT.
- WAIT:
  - `done[stg]` = 1: if `stg` == N_STAGES-1, go to FINISH. Otherwise increment `stg` and go to START.
  - `done` = 0 and `wait_cnt` == TIMEOUT-1: set `timeout_err` and treat the stage as done (same transitions as above).
  - Otherwise: increment `wait_cnt`.
  - `done` bits other than `done[stg]` are ignored.
- FINISH: `frame_done` = 1 for one cycle, then go to IDLE.
- `start` and `frame_done` are decoded from the state register, so they are glitch-free Moore outputs.
- `busy` = (state != IDLE).
- A `tick` in any state other than IDLE sets `overrun` and is dropped. It does not increment the counter and does not queue.
- `playing` falling mid-sequence: the current sequence runs to completion; no abort.
- `clear_err`: clears `overrun` and `timeout_err` next edge. If a set condition occurs in the same cycle, set wins.
- Reset (async, any time, including mid-sequence):
  - state = IDLE, `stg` = 0, `wait_cnt` = 0.
  - `start` = 0, `frame_done` = 0, `busy` = 0.
  - `frame_counter` = 0, `overrun` = 0, `timeout_err` = 0.
  - s1, s2 and s3 = 1.
  - If `frame_clk` is low when reset releases, no tick is produced until the next full high-to-low transition.

## Timing
- `frame_clk` is first sampled low at edge E0. Then s2 = 0 after E1, and `tick` is high in the cycle E1 to E2.
- At E2 the FSM enters START and `frame_counter` increments. `start[0]` is high from E2 to E3.
- A stage whose `done` is high in the first WAIT cycle has a stage-to-stage gap of 2 cycles: `start[k]` at cycle t, `start[k+1]` at cycle t+2.
- Minimum sequence length from START[0] to the end of FINISH is 2·N_STAGES+1 cycles, which is 7 for N_STAGES = 3.
- A stage that never completes adds exactly TIMEOUT cycles in WAIT.
- Worst case is well under one frame: 3·4096 cycles, about 0.25 ms, against a 16.7 ms frame.

## Test plan
- **Normal frame.** `playing`=1. Drive `frame_clk` low; each engine returns `done` 1 cycle after its `start`. Required: `start[0]` 2 cycles after first low sample, `start` pulses 0,1,2 each one cycle wide and 2 cycles apart, `frame_done` once, `frame_counter` 0→1, `busy` then low.
- **Paused.** `playing`=0 and 5 VS pulses. Required: no `start` pulses, `frame_counter` stays 0, `busy` stays 0.
- **Hung stage.** `done[1]` held low with TIMEOUT=16. Required: `start[2]` exactly 16 WAIT cycles after `start[1]`+1, `timeout_err`=1, `frame_done` still pulses. `clear_err` then returns the flag to 0.
- **Overrun.** Second VS falling edge while stage 0 waits. Required: `overrun`=1, `frame_counter` increments only once, exactly one `frame_done`.
- **Wrap.** Run 4096 frames. Required: `frame_counter` goes 4095→0 with no glitch.
- **Reset mid-sequence.** Assert `Reset` during WAIT of stage 1, asynchronously between edges. Required: all outputs at reset values immediately. After release with `frame_clk` held low, there is no `start` until a new high-to-low VS transition.

Source files
------------

// File: rtl/frame_scheduler.sv
// frame_scheduler
//   Per-frame update sequencer. It detects the falling edge of VS (frame_clk) inside the Clk
//   domain. It then runs N_STAGES update engines strictly one after another, using a start/done
//   handshake, and counts played frames. It also raises sticky flags when a frame overruns or
//   a stage hangs.
//
// Parameters
//   N_STAGES  number of sequenced engines; stage 0 runs first
//   TIMEOUT   maximum Clk cycles spent waiting for done in one stage
//   CNT_W     width of frame_counter
//
// Ports
//   Clk            system clock
//   Reset          asynchronous, active-high reset
//   frame_clk      VGA_VS, active-low sync, asynchronous to Clk
//   playing        when low, ticks are ignored and the counter holds
//   done           per-stage completion, sampled only while waiting on that stage
//   clear_err      one-cycle clear of overrun / timeout_err (a same-cycle set wins)
//   start          one-cycle, one-hot start pulse per stage
//   busy           sequencer not idle
//   frame_done     one-cycle pulse after the last stage completes
//   frame_counter  frames played, wraps modulo 2**CNT_W
//   overrun        sticky: VS edge arrived while a sequence was running
//   timeout_err    sticky: a stage exceeded TIMEOUT cycles
module frame_scheduler #(
   parameter int unsigned N_STAGES = 3,
   parameter int unsigned TIMEOUT  = 4096,
   parameter int unsigned CNT_W    = 12
) (
   input  logic                Clk,
   input  logic                Reset,
   input  logic                frame_clk,
   input  logic                playing,
   input  logic [N_STAGES-1:0] done,
   input  logic                clear_err,
   output logic [N_STAGES-1:0] start,
   output logic                busy,
   output logic                frame_done,
   output logic [CNT_W-1:0]    frame_counter,
   output logic                overrun,
   output logic                timeout_err
);

   localparam int unsigned StgW  = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
   localparam int unsigned WaitW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [StgW-1:0]  LastStg = StgW'(N_STAGES - 1);
   localparam logic [WaitW-1:0] WaitMax = WaitW'(TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StStart, StWait, StFinish} state_e;

   state_e             state_q, state_d;
   logic [StgW-1:0]    stg_q, stg_d;
   logic [WaitW-1:0]   wait_cnt_q, wait_cnt_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               overrun_q, overrun_d;
   logic               timeout_q, timeout_d;
   logic               s1_q, s2_q, s3_q;
   logic [2:0]         sync_vld_q;
   logic               tick;
   logic               set_timeout;
   logic               stage_done;
   logic               done_cur;
   logic [N_STAGES-1:0] stg_onehot;

   // --------------------------------------------------------------------------------------------
   // VS synchronizer and falling-edge detector
   // --------------------------------------------------------------------------------------------
   // sync_vld_q marks which synchronizer flops hold a real sample rather than their reset value.
   // Without it, a VS already low at reset release would look like a falling edge.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         s1_q       <= 1'b1;
         s2_q       <= 1'b1;
         s3_q       <= 1'b1;
         sync_vld_q <= '0;
      end else begin
         s1_q       <= frame_clk;
         s2_q       <= s1_q;
         s3_q       <= s2_q;
         sync_vld_q <= {sync_vld_q[1:0], 1'b1};
      end
   end

   assign tick = s3_q & ~s2_q & sync_vld_q[2];

   // --------------------------------------------------------------------------------------------
   // Stage decode
   // --------------------------------------------------------------------------------------------
   assign stg_onehot = N_STAGES'(1) << stg_q;
   // Only the current stage's done bit matters; the others are masked off.
   assign done_cur   = |(done & stg_onehot);

   // --------------------------------------------------------------------------------------------
   // Sequencer FSM
   // --------------------------------------------------------------------------------------------
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state_q    <= StIdle;
         stg_q      <= '0;
         wait_cnt_q <= '0;
         cnt_q      <= '0;
         overrun_q  <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         stg_q      <= stg_d;
         wait_cnt_q <= wait_cnt_d;
         cnt_q      <= cnt_d;
         overrun_q  <= overrun_d;
         timeout_q  <= timeout_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      stg_d       = stg_q;
      wait_cnt_d  = wait_cnt_q;
      cnt_d       = cnt_q;
      set_timeout = 1'b0;
      stage_done  = 1'b0;

      unique case (state_q)
         StIdle: begin
            if (tick && playing) begin
               stg_d   = '0;
               cnt_d   = cnt_q + 1'b1;
               state_d = StStart;
            end
         end
         StStart: begin
            wait_cnt_d = '0;
            state_d    = StWait;
         end
         StWait: begin
            if (done_cur) begin
               stage_done = 1'b1;
            end else if (wait_cnt_q == WaitMax) begin
               // A hung engine is abandoned so the remaining stages still run this frame.
               stage_done  = 1'b1;
               set_timeout = 1'b1;
            end else begin
               wait_cnt_d = wait_cnt_q + 1'b1;
            end
            if (stage_done) begin
               if (stg_q == LastStg) begin
                  state_d = StFinish;
               end else begin
                  stg_d   = stg_q + 1'b1;
                  state_d = StStart;
               end
            end
         end
         StFinish: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // --------------------------------------------------------------------------------------------
   // Sticky error flags; a set in the same cycle as clear_err wins
   // --------------------------------------------------------------------------------------------
   always_comb begin
      overrun_d = (tick && (state_q != StIdle)) | (overrun_q & ~clear_err);
      timeout_d = set_timeout | (timeout_q & ~clear_err);
   end

   // --------------------------------------------------------------------------------------------
   // Moore outputs, decoded from registered state
   // --------------------------------------------------------------------------------------------
   assign start         = (state_q == StStart) ? stg_onehot : '0;
   assign busy          = (state_q != StIdle);
   assign frame_done    = (state_q == StFinish);
   assign frame_counter = cnt_q;
   assign overrun       = overrun_q;
   assign timeout_err   = timeout_q;

endmodule

// File: tb/tb_frame_scheduler.sv
// Scoreboard bench for frame_scheduler. Stimulus computes, from the timing rules, when each
// start pulse and frame_done must appear and what frame_counter / timeout_err must then read.
// A separate monitor matches every start and frame_done against the queued expectation.
module tb_frame_scheduler;

   localparam int N  = 3;
   localparam int TO = 16;
   localparam int CW = 12;

   logic          Clk       = 1'b0;
   logic          Reset     = 1'b1;
   logic          frame_clk = 1'b1;
   logic          playing   = 1'b0;
   logic          clear_err = 1'b0;
   logic [N-1:0]  done      = '0;
   logic [N-1:0]  start;
   logic          busy;
   logic          frame_done;
   logic [CW-1:0] frame_counter;
   logic          overrun;
   logic          timeout_err;

   int checks   = 0;
   int errors   = 0;
   int cyc      = 0;
   int busy_cnt = 0;
   int lat [N];
   bit mon_act  = 1'b0;

   typedef struct {
      logic [N-1:0][31:0] ts;
      int                 fd;
      int                 cnt;
      bit                 to;
   } exp_t;

   exp_t exp_q [$];
   int   m_cnt = 0;
   bit   m_to  = 1'b0;
   bit   m_ov  = 1'b0;

   frame_scheduler #(
      .N_STAGES (N),
      .TIMEOUT  (TO),
      .CNT_W    (CW)
   ) dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .frame_clk     (frame_clk),
      .playing       (playing),
      .done          (done),
      .clear_err     (clear_err),
      .start         (start),
      .busy          (busy),
      .frame_done    (frame_done),
      .frame_counter (frame_counter),
      .overrun       (overrun),
      .timeout_err   (timeout_err)
   );

   always #5 Clk = ~Clk;
   always @(posedge Clk) cyc <= cyc + 1;

   task automatic check(input bit ok, input string name, input longint act, input longint req);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Expected response of one played frame, from the timing rules: start[0] three cycles after
   // the cycle in which VS is driven low; each stage occupies 1 START cycle plus min(latency,
   // TIMEOUT) WAIT cycles; frame_done follows the last stage the same way.
   function automatic exp_t build(input int n);
      exp_t e;
      int   t;
      int   eff;
      bit   hung;
      hung  = 1'b0;
      m_cnt = (m_cnt + 1) % (1 << CW);
      e.cnt = m_cnt;
      t     = n + 3;
      for (int k = 0; k < N; k++) begin
         e.ts[k] = t;
         if (lat[k] < 1 || lat[k] > TO) begin
            eff  = TO;
            hung = 1'b1;
         end else begin
            eff = lat[k];
         end
         t = t + 1 + eff;
      end
      e.fd = t;
      m_to = m_to | hung;
      e.to = m_to;
      return e;
   endfunction

   function automatic int rnd_lat();
      if ($urandom_range(0, 9) == 0) return 0;
      return int'($urandom_range(1, 4));
   endfunction

   // Engine model: raises done[k] for one cycle, lat[k] cycles after start[k]; 0 means never.
   initial begin
      int cnt [N];
      for (int k = 0; k < N; k++) cnt[k] = 0;
      forever begin
         @(negedge Clk);
         for (int k = 0; k < N; k++) begin
            if (Reset) begin
               cnt[k]  = 0;
               done[k] = 1'b0;
            end else if (start[k]) begin
               cnt[k]  = lat[k];
               done[k] = 1'b0;
            end else if (cnt[k] > 0) begin
               cnt[k]--;
               done[k] = (cnt[k] == 0);
            end else begin
               done[k] = 1'b0;
            end
         end
      end
   end

   // Monitor
   initial begin
      exp_t         cur;
      int           stage;
      logic [N-1:0] want;
      stage = 0;
      forever begin
         @(negedge Clk);
         if (Reset) begin
            exp_q.delete();
            mon_act = 1'b0;
         end else begin
            if (busy) busy_cnt++;
            if (start != '0) begin
               check($onehot(start), "start_onehot", start, 0);
               if (start[0]) begin
                  if (mon_act) check(1'b0, "start0_while_active", start, 0);
                  if (exp_q.size() == 0) begin
                     check(1'b0, "unexpected_start0", start, 0);
                  end else begin
                     cur     = exp_q.pop_front();
                     mon_act = 1'b1;
                     stage   = 0;
                  end
               end
               if (mon_act) begin
                  if (stage >= N) begin
                     check(1'b0, "extra_start", stage, N - 1);
                  end else begin
                     want = N'(1) << stage;
                     check(start == want, "start_order", start, want);
                     check(cyc == int'(cur.ts[stage]), "start_cycle", cyc, cur.ts[stage]);
                     stage++;
                  end
               end else if (!start[0]) begin
                  check(1'b0, "unexpected_start", start, 0);
               end
            end
            if (frame_done) begin
               if (!mon_act) begin
                  check(1'b0, "unexpected_frame_done", frame_done, 0);
               end else begin
                  check(cyc == cur.fd, "frame_done_cycle", cyc, cur.fd);
                  check(frame_counter == CW'(cur.cnt), "frame_counter", frame_counter, cur.cnt);
                  check(timeout_err == cur.to, "timeout_err", timeout_err, cur.to);
                  check(stage == N, "stages_run", stage, N);
                  mon_act = 1'b0;
               end
            end
         end
      end
   end

   // One VS pulse. When play is set the frame is expected to run; drop lowers playing mid-run.
   task automatic run_frame(input bit play, input int l0, input int l1, input int l2,
                            input bit drop, input int gap);
      exp_t e;
      int   n;
      int   fd;
      @(negedge Clk);
      playing   = play;
      lat[0]    = l0;
      lat[1]    = l1;
      lat[2]    = l2;
      frame_clk = 1'b0;
      n         = cyc;
      fd        = n + 6;
      if (play) begin
         e  = build(n);
         exp_q.push_back(e);
         fd = e.fd;
      end
      repeat (3) @(negedge Clk);
      frame_clk = 1'b1;
      if (drop) playing = 1'b0;
      while (cyc < fd + 2 + gap) @(negedge Clk);
   endtask

   task automatic pulse_clear();
      @(negedge Clk);
      clear_err = 1'b1;
      @(negedge Clk);
      clear_err = 1'b0;
      m_to      = 1'b0;
      m_ov      = 1'b0;
      check(timeout_err == m_to, "clear_timeout_err", timeout_err, m_to);
      check(overrun == m_ov, "clear_overrun", overrun, m_ov);
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: got cycle %0d, expected completion", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      exp_t e;
      int   n;
      int   b0;
      int   frames;
      bit   play;
      bit   drop;
      for (int k = 0; k < N; k++) lat[k] = 1;

      // Reset state
      repeat (3) @(negedge Clk);
      check(start == '0, "rst_start", start, 0);
      check(busy == 1'b0, "rst_busy", busy, 0);
      check(frame_done == 1'b0, "rst_frame_done", frame_done, 0);
      check(frame_counter == CW'(m_cnt), "rst_counter", frame_counter, m_cnt);
      check(overrun == m_ov, "rst_overrun", overrun, m_ov);
      check(timeout_err == m_to, "rst_timeout_err", timeout_err, m_to);
      Reset = 1'b0;
      repeat (4) @(negedge Clk);

      // Normal frame
      run_frame(1'b1, 1, 1, 1, 1'b0, 0);
      check(frame_counter == CW'(m_cnt), "normal_counter", frame_counter, m_cnt);
      check(busy == 1'b0, "normal_busy_after", busy, 0);
      check(overrun == m_ov, "normal_overrun", overrun, m_ov);

      // Paused
      b0 = busy_cnt;
      repeat (5) run_frame(1'b0, 1, 1, 1, 1'b0, 0);
      check(busy_cnt == b0, "paused_busy_cycles", busy_cnt - b0, 0);
      check(frame_counter == CW'(m_cnt), "paused_counter", frame_counter, m_cnt);

      // Hung stage 1
      run_frame(1'b1, 1, 0, 1, 1'b0, 0);
      check(timeout_err == m_to, "hung_timeout_err", timeout_err, m_to);
      pulse_clear();

      // Overrun: second VS falling edge while stage 0 waits
      @(negedge Clk);
      playing   = 1'b1;
      lat[0]    = 10;
      lat[1]    = 1;
      lat[2]    = 1;
      frame_clk = 1'b0;
      n         = cyc;
      e         = build(n);
      exp_q.push_back(e);
      repeat (3) @(negedge Clk);
      frame_clk = 1'b1;
      repeat (3) @(negedge Clk);
      frame_clk = 1'b0;
      m_ov      = 1'b1;
      repeat (3) @(negedge Clk);
      frame_clk = 1'b1;
      while (cyc < e.fd + 2) @(negedge Clk);
      check(overrun == m_ov, "overrun_set", overrun, m_ov);
      check(frame_counter == CW'(m_cnt), "overrun_counter", frame_counter, m_cnt);
      pulse_clear();

      // Randomized frames
      for (int i = 0; i < 150; i++) begin
         play = ($urandom_range(0, 5) != 0);
         drop = play && ($urandom_range(0, 3) == 0);
         run_frame(play, rnd_lat(), rnd_lat(), rnd_lat(), drop, int'($urandom_range(0, 3)));
         if ($urandom_range(0, 3) == 0) pulse_clear();
      end
      check(frame_counter == CW'(m_cnt), "random_counter", frame_counter, m_cnt);
      check(overrun == m_ov, "random_overrun", overrun, m_ov);

      // Reset asserted between edges during WAIT of stage 1
      @(negedge Clk);
      playing   = 1'b1;
      lat[0]    = 1;
      lat[1]    = 0;
      lat[2]    = 1;
      frame_clk = 1'b0;
      n         = cyc;
      e         = build(n);
      exp_q.push_back(e);
      repeat (3) @(negedge Clk);
      frame_clk = 1'b1;
      while (cyc < n + 10) @(negedge Clk);
      #2;
      Reset     = 1'b1;
      frame_clk = 1'b0;
      #1;
      m_cnt = 0;
      m_to  = 1'b0;
      m_ov  = 1'b0;
      check(start == '0, "async_rst_start", start, 0);
      check(busy == 1'b0, "async_rst_busy", busy, 0);
      check(frame_done == 1'b0, "async_rst_frame_done", frame_done, 0);
      check(frame_counter == CW'(m_cnt), "async_rst_counter", frame_counter, m_cnt);
      check(overrun == m_ov, "async_rst_overrun", overrun, m_ov);
      check(timeout_err == m_to, "async_rst_timeout_err", timeout_err, m_to);
      repeat (3) @(negedge Clk);
      Reset = 1'b0;
      b0    = busy_cnt;
      repeat (12) @(negedge Clk);
      check(busy_cnt == b0, "no_tick_after_reset", busy_cnt - b0, 0);
      check(frame_counter == CW'(m_cnt), "post_reset_counter", frame_counter, m_cnt);
      frame_clk = 1'b1;
      repeat (3) @(negedge Clk);
      run_frame(1'b1, 1, 1, 1, 1'b0, 0);
      check(frame_counter == CW'(m_cnt), "post_reset_frame", frame_counter, m_cnt);

      // Counter wrap: run past 2**CW - 1
      frames = (1 << CW) - m_cnt + 2;
      repeat (frames) run_frame(1'b1, 1, 1, 1, 1'b0, 0);
      check(frame_counter == CW'(m_cnt), "wrap_counter", frame_counter, m_cnt);
      check(overrun == m_ov, "wrap_overrun", overrun, m_ov);

      check(exp_q.size() == 0 && !mon_act, "pending_expectations", exp_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
